// File: rtl/m68k_bus_sequencer_pkg.sv
// Shared types and constants for the Wishbone-to-68000 bus sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, WB_SEL lane encodings, timeout default, 68k address width.
package neogeo_bus_pkg;

  localparam int M68K_ADDR_W        = 23;  // A23..A1
  localparam int WB_ADR_W           = 22;  // byte address bits [23:2]
  localparam int TIMEOUT_CYCLES_DEF = 32;

  // WB_SEL encodings accepted by the sequencer (bit 3 = D31:24).
  localparam logic [3:0] SEL_HI_UPPER = 4'b1000;  // A1=0, UDS
  localparam logic [3:0] SEL_HI_LOWER = 4'b0100;  // A1=0, LDS
  localparam logic [3:0] SEL_HI_WORD  = 4'b1100;  // A1=0, UDS+LDS
  localparam logic [3:0] SEL_LO_UPPER = 4'b0010;  // A1=1, UDS
  localparam logic [3:0] SEL_LO_LOWER = 4'b0001;  // A1=1, LDS
  localparam logic [3:0] SEL_LO_WORD  = 4'b0011;  // A1=1, UDS+LDS
  localparam logic [3:0] SEL_LONG     = 4'b1111;  // two word cycles, A1=0 then A1=1

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_STROBE,
    ST_LATCH,
    ST_DONE,
    ST_FAULT
  } bus_state_e;

endpackage

// File: rtl/m68k_bus_sequencer_if.sv
// Bundles the Wishbone request side and the 68000 bus side of the sequencer.
// Latency: n/a (wiring only).
// Backpressure: WB_STB is held by the requester until WB_ACK or WB_ERR.
// Modports: slave = the sequencer; master = the Wishbone requester plus 68k bus environment.
interface m68k_bus_sequencer_if;
  import neogeo_bus_pkg::*;

  logic [WB_ADR_W-1:0]    WB_ADR;
  logic [31:0]            WB_DATW;
  logic [3:0]             WB_SEL;
  logic                   WB_STB;
  logic                   WB_WE;
  logic [31:0]            WB_DATR;
  logic                   WB_ACK;
  logic                   WB_ERR;
  logic [M68K_ADDR_W-1:0] M68K_ADDR;
  logic [15:0]            M68K_DOUT;
  logic                   M68K_DOE;
  logic [15:0]            M68K_DIN;
  logic                   M68K_RW;
  logic                   nAS;
  logic                   nUDS;
  logic                   nLDS;
  logic                   nDTACK;

  modport slave (
    input  WB_ADR, WB_DATW, WB_SEL, WB_STB, WB_WE, M68K_DIN, nDTACK,
    output WB_DATR, WB_ACK, WB_ERR, M68K_ADDR, M68K_DOUT, M68K_DOE, M68K_RW,
           nAS, nUDS, nLDS
  );

  modport master (
    output WB_ADR, WB_DATW, WB_SEL, WB_STB, WB_WE, M68K_DIN, nDTACK,
    input  WB_DATR, WB_ACK, WB_ERR, M68K_ADDR, M68K_DOUT, M68K_DOE, M68K_RW,
           nAS, nUDS, nLDS
  );

endinterface

// File: rtl/m68k_lane_decode.sv
// Maps a Wishbone byte-lane select plus the longword half flag to A1/UDS/LDS.
// Latency: combinational.
// Backpressure: none.
// Ports: sel (WB_SEL), half (0 = first/only word) -> a1, uds, lds (active-high), legal.
module m68k_lane_decode
  import neogeo_bus_pkg::*;
(
  input  logic [3:0] sel,
  input  logic       half,
  output logic       a1,
  output logic       uds,
  output logic       lds,
  output logic       legal
);

  always_comb begin
    a1    = 1'b0;
    uds   = 1'b0;
    lds   = 1'b0;
    legal = 1'b1;
    case (sel)
      SEL_HI_UPPER: uds = 1'b1;
      SEL_HI_LOWER: lds = 1'b1;
      SEL_HI_WORD:  begin uds = 1'b1; lds = 1'b1; end
      SEL_LO_UPPER: begin a1 = 1'b1; uds = 1'b1; end
      SEL_LO_LOWER: begin a1 = 1'b1; lds = 1'b1; end
      SEL_LO_WORD:  begin a1 = 1'b1; uds = 1'b1; lds = 1'b1; end
      // Longword: high word goes out first, so A1 simply follows the half flag.
      SEL_LONG:     begin a1 = half; uds = 1'b1; lds = 1'b1; end
      default:      legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/m68k_bus_sequencer.sv
// Converts single Wishbone requests into 68000 asynchronous bus cycles (longwords as two word cycles).
// Latency: word = 4 cycles from acceptance to WB_ACK with zero wait states, longword = 7; +1 per DTACK wait.
// Backpressure: one request in flight; WB_STB is only sampled in IDLE, the 68k side stalls on nDTACK.
// Ports: CLK_68KCLK, nRESET (async, active-low), bus (m68k_bus_sequencer_if.slave).
// Optional: define NEOGEO_BUSTIMEOUT_EN to abort a STROBE phase after TIMEOUT_CYCLES without DTACK.
module m68k_bus_sequencer
  import neogeo_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                 CLK_68KCLK,
  input  logic                 nRESET,
  m68k_bus_sequencer_if.slave  bus
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  bus_state_e             state_q, state_d;
  logic                   half_q;
  logic [WB_ADR_W-1:0]    adr_q;
  logic [3:0]             sel_q;
  logic                   we_q;
  logic [15:0]            datw_lo_q;
  logic                   uds_q, lds_q;
  logic [M68K_ADDR_W-1:0] addr_q;
  logic [15:0]            dout_q;
  logic [31:0]            datr_q;

  logic                   dec_a1, dec_uds, dec_lds, dec_legal;
  logic                   long_first;
  logic                   tmo_hit;
  logic                   active;

  // Single decoder: in IDLE it judges the incoming request; in LATCH it
  // precomputes the lanes for the second longword half.
  m68k_lane_decode u_lane_decode (
    .sel   ((state_q == ST_IDLE) ? bus.WB_SEL : sel_q),
    .half  (state_q == ST_LATCH),
    .a1    (dec_a1),
    .uds   (dec_uds),
    .lds   (dec_lds),
    .legal (dec_legal)
  );

  assign long_first = (sel_q == SEL_LONG) && !half_q;

`ifdef NEOGEO_BUSTIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt_q;

  always_ff @(posedge CLK_68KCLK or negedge nRESET) begin
    if (!nRESET)                  tmo_cnt_q <= '0;
    else if (state_q == ST_STROBE) tmo_cnt_q <= tmo_cnt_q + 1'b1;
    else                          tmo_cnt_q <= '0;
  end

  // Counter holds the number of STROBE cycles already completed.
  assign tmo_hit = (state_q == ST_STROBE) && (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge CLK_68KCLK or negedge nRESET) begin
    if (!nRESET) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (bus.WB_STB) state_d = dec_legal ? ST_ADDR : ST_FAULT;
      ST_ADDR:   state_d = ST_STROBE;
      // DTACK wins over a timeout landing on the same cycle.
      ST_STROBE: if (!bus.nDTACK) state_d = ST_LATCH;
                 else if (tmo_hit) state_d = ST_FAULT;
      ST_LATCH:  state_d = long_first ? ST_ADDR : ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      ST_FAULT:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_68KCLK or negedge nRESET) begin
    if (!nRESET) begin
      half_q    <= 1'b0;
      adr_q     <= '0;
      sel_q     <= '0;
      we_q      <= 1'b0;
      datw_lo_q <= '0;
      uds_q     <= 1'b0;
      lds_q     <= 1'b0;
      addr_q    <= '0;
      dout_q    <= '0;
      datr_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.WB_STB) begin
          adr_q     <= bus.WB_ADR;
          sel_q     <= bus.WB_SEL;
          we_q      <= bus.WB_WE;
          datw_lo_q <= bus.WB_DATW[15:0];
          half_q    <= 1'b0;
          datr_q    <= '0;
          if (dec_legal) begin
            addr_q <= {bus.WB_ADR, dec_a1};
            dout_q <= dec_a1 ? bus.WB_DATW[15:0] : bus.WB_DATW[31:16];
            uds_q  <= dec_uds;
            lds_q  <= dec_lds;
          end
        end
        ST_STROBE: if (state_d == ST_FAULT) begin
          datr_q <= '0;
          half_q <= 1'b0;
        end
        ST_LATCH: begin
          if (!we_q) begin
            if (addr_q[0]) datr_q[15:0]  <= bus.M68K_DIN;
            else           datr_q[31:16] <= bus.M68K_DIN;
          end
          if (long_first) begin
            half_q <= 1'b1;
            addr_q <= {adr_q, dec_a1};
            dout_q <= datw_lo_q;
            uds_q  <= dec_uds;
            lds_q  <= dec_lds;
          end
        end
        default: ;
      endcase
    end
  end

  // Direction and drive only leave their idle values while a bus cycle is in
  // progress, so reset and IDLE both present a released bus.
  assign active = (state_q == ST_ADDR) || (state_q == ST_STROBE) || (state_q == ST_LATCH);

  assign bus.nAS       = !(state_q == ST_STROBE);
  assign bus.nUDS      = !((state_q == ST_STROBE) && uds_q);
  assign bus.nLDS      = !((state_q == ST_STROBE) && lds_q);
  assign bus.M68K_RW   = !(we_q && active);
  assign bus.M68K_DOE  = we_q && active;
  assign bus.M68K_ADDR = addr_q;
  assign bus.M68K_DOUT = dout_q;
  assign bus.WB_DATR   = datr_q;
  assign bus.WB_ACK    = (state_q == ST_DONE);
  assign bus.WB_ERR    = (state_q == ST_FAULT);

endmodule
